rl_pair_dispatcher: RTL and testbench
=====================================

RL_PAIR_DISPATCHER -- requirements
Module: rl_pair_dispatcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the IEEE-754 single-precision coordinate width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, the home and neighbour position BRAM address width.
REQ-003 SHALL have parameter HOME_NUM, default 512, the number of home particles (range 1..2^ADDR_WIDTH).
REQ-004 SHALL have parameter NEIGHBOR_NUM, default 512, the number of neighbour particles (range 1..2^ADDR_WIDTH).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-008 start  input  1  single-cycle request to begin a full home x neighbour sweep.
REQ-009 home_rdaddr  output  ADDR_WIDTH  read address to the refx/refy/refz BRAMs.
REQ-010 neighbor_rdaddr  output  ADDR_WIDTH  read address to the neighborx/y/z BRAMs.
REQ-011 rden  output  1  read enable to all six BRAMs; q is valid exactly 1 cycle after rden.
REQ-012 home_x/home_y/home_z, nb_x/nb_y/nb_z  input  DATA_WIDTH each  BRAM q data.
REQ-013 refx, refy, refz, neighborx, neighbory, neighborz  output  DATA_WIDTH each  pair coordinates to r2_compute.
REQ-014 pair_home_id  output  ADDR_WIDTH  home index of the presented pair.
REQ-015 pair_valid  output  1  a pair is presented.
REQ-016 pair_ready  input  1  downstream accepts; transfer occurs when pair_valid && pair_ready.
REQ-017 pair_last  output  1  the presented pair is the final pair of the sweep.
REQ-018 busy  output  1  high from leaving IDLE until DONE is exited.
REQ-019 done  output  1  single-cycle pulse at sweep completion.

Function
REQ-020 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-021 IDLE: on start=1, addresses load 0, next state RUN; start is ignored in every other state.
REQ-022 RUN: issue order SHALL be neighbour-major inner loop: (h,0),(h,1)..(h,NEIGHBOR_NUM-1),(h+1,0)...
REQ-023 Each cycle rden=1, neighbor_rdaddr SHALL advance by 1; at NEIGHBOR_NUM-1 it wraps to 0 and home_rdaddr increments.
REQ-024 On issuing (HOME_NUM-1, NEIGHBOR_NUM-1), the FSM SHALL enter DRAIN and rden SHALL stay 0 until the next sweep.
REQ-025 SHALL contain a 2-entry pair FIFO capturing BRAM q plus home id and last flag, 1 cycle after each rden.
REQ-026 Credit rule: rden=1 only in RUN and when (FIFO occupancy + reads in flight - pop this cycle) < 2; the FIFO never overflows.
REQ-027 Output registers SHALL reflect the FIFO head; pair_valid = FIFO not empty; pop on pair_valid && pair_ready.
REQ-028 Output data SHALL remain stable while pair_valid=1 and pair_ready=0.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged, with no bubble and no data loss.
REQ-030 Throughput with pair_ready held at 1 SHALL be one pair per cycle after a 2-cycle start-up (start -> first pair_valid = 3 cycles).
REQ-031 DRAIN -> DONE when FIFO empty and no read in flight; DONE asserts done=1 for one cycle, then IDLE.
REQ-032 Exactly HOME_NUM*NEIGHBOR_NUM transfers per sweep, with pair_last=1 only on the final transfer.
REQ-033 HOME_NUM=1 or NEIGHBOR_NUM=1 SHALL work, including the 1x1 sweep (single pair, pair_last=1).

Reset
REQ-034 rst=0 SHALL asynchronously force state IDLE, all addresses 0, rden 0, FIFO empty, pair_valid 0, pair_last 0, busy 0, done 0, and coordinate outputs 0.
REQ-035 Reset mid-sweep SHALL discard in-flight and buffered pairs; no done pulse is emitted for an aborted sweep.
REQ-036 After deassertion, the block SHALL accept start on the first clock edge.

Verification (HOME_NUM=4, NEIGHBOR_NUM=4 unless noted; BRAM model stores value = address)
REQ-037 start pulse, pair_ready=1 -> 16 pairs on 16 consecutive cycles, first at start+3; pair_home_id 0,0,0,0,1..3; neighborx 0,1,2,3 repeating; pair_last on the 16th; done 1 cycle after DRAIN empties.
REQ-038 pair_ready toggling 1,0 -> 16 transfers in the same order, data stable during stalls, never more than 2 rden ahead of acceptances.
REQ-039 pair_ready=0 for 20 cycles after start -> exactly 2 reads issued, pair_valid=1 holding pair (0,0); then ready=1 -> remaining 14 pairs follow in order.
REQ-040 start re-pulsed during RUN -> ignored, count still 16, one done.
REQ-041 rst=0 after 7 transfers with FIFO full -> outputs reset immediately; new start yields a full 16-pair sweep from (0,0).
REQ-042 HOME_NUM=1, NEIGHBOR_NUM=1 -> a single pair with pair_last=1, then done.

Source files
------------

// File: rtl/rl_pair_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : rl_pair_dispatcher
//  Description : Sweeps every (home, neighbour) particle pair by reading the
//                position BRAMs, buffers the returned coordinates in a
//                2-entry pair FIFO and presents them on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rl_pair_dispatcher #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int HOME_NUM     = 512,
  parameter int NEIGHBOR_NUM = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] home_rdaddr,
  output logic [ADDR_WIDTH-1:0] neighbor_rdaddr,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] home_x,
  input  logic [DATA_WIDTH-1:0] home_y,
  input  logic [DATA_WIDTH-1:0] home_z,
  input  logic [DATA_WIDTH-1:0] nb_x,
  input  logic [DATA_WIDTH-1:0] nb_y,
  input  logic [DATA_WIDTH-1:0] nb_z,
  output logic [DATA_WIDTH-1:0] refx,
  output logic [DATA_WIDTH-1:0] refy,
  output logic [DATA_WIDTH-1:0] refz,
  output logic [DATA_WIDTH-1:0] neighborx,
  output logic [DATA_WIDTH-1:0] neighbory,
  output logic [DATA_WIDTH-1:0] neighborz,
  output logic [ADDR_WIDTH-1:0] pair_home_id,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic                  pair_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FIFO entry: six coordinates, home id, last flag (head slot is always [0])
  localparam int                    c_entry_w   = 6*DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] c_home_last = ADDR_WIDTH'(HOME_NUM-1);
  localparam logic [ADDR_WIDTH-1:0] c_nb_last   = ADDR_WIDTH'(NEIGHBOR_NUM-1);
  localparam logic [ADDR_WIDTH-1:0] c_one       = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] home_addr_q, home_addr_d;
  logic [ADDR_WIDTH-1:0] nb_addr_q, nb_addr_d;
  // Metadata of the read issued last cycle, paired with the q data now
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] fl_home_q, fl_home_d;
  logic                  fl_last_q, fl_last_d;
  logic [1:0]            count_q, count_d;
  logic [c_entry_w-1:0]  fifo_q [2];
  logic [c_entry_w-1:0]  fifo_d [2];

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_credit;
  logic                  w_issue_last;
  logic                  w_head_last;
  logic [c_entry_w-1:0]  w_push_entry;

  assign w_pop        = (count_q != 2'd0) && pair_ready;
  assign w_occ        = {1'b0, count_q} + {2'b00, inflight_q};
  // A new read may only go out if its data is guaranteed a FIFO slot
  assign w_credit     = w_occ < (3'd2 + {2'b00, w_pop});
  assign rden         = (state_q == S_RUN) && w_credit;
  assign w_issue_last = (home_addr_q == c_home_last) && (nb_addr_q == c_nb_last);
  assign w_push_entry = {home_x, home_y, home_z, nb_x, nb_y, nb_z, fl_home_q, fl_last_q};

  assign home_rdaddr     = home_addr_q;
  assign neighbor_rdaddr = nb_addr_q;
  assign {refx, refy, refz, neighborx, neighbory, neighborz, pair_home_id, w_head_last} = fifo_q[0];
  assign pair_valid      = (count_q != 2'd0);
  assign pair_last       = w_head_last && pair_valid;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

  // Next-state: sweep FSM, address walk and FIFO push/pop
  always_comb begin
    state_d     = state_q;
    home_addr_d = home_addr_q;
    nb_addr_d   = nb_addr_q;
    fl_home_d   = fl_home_q;
    fl_last_d   = fl_last_q;
    inflight_d  = rden;
    count_d     = count_q;
    fifo_d      = fifo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          home_addr_d = '0;
          nb_addr_d   = '0;
        end
      end
      S_RUN: begin
        if (rden) begin
          fl_home_d = home_addr_q;
          fl_last_d = w_issue_last;
          if (nb_addr_q == c_nb_last) begin
            nb_addr_d = '0;
            if (w_issue_last) begin
              home_addr_d = '0;
              state_d     = S_DRAIN;
            end else begin
              home_addr_d = home_addr_q + c_one;
            end
          end else begin
            nb_addr_d = nb_addr_q + c_one;
          end
        end
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Push happens on the cycle the BRAM q is valid; the credit rule
    // guarantees a free slot, so only occupancy 0/1 is seen on push-only.
    case ({inflight_q, w_pop})
      2'b10: begin
        if (count_q == 2'd0) fifo_d[0] = w_push_entry;
        else                 fifo_d[1] = w_push_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0] = fifo_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          fifo_d[0] = w_push_entry;
        end else begin
          fifo_d[0] = fifo_q[1];
          fifo_d[1] = w_push_entry;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      home_addr_q <= '0;
      nb_addr_q   <= '0;
      inflight_q  <= 1'b0;
      fl_home_q   <= '0;
      fl_last_q   <= 1'b0;
      count_q     <= 2'd0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      home_addr_q <= home_addr_d;
      nb_addr_q   <= nb_addr_d;
      inflight_q  <= inflight_d;
      fl_home_q   <= fl_home_d;
      fl_last_q   <= fl_last_d;
      count_q     <= count_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rl_pair_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rl_pair_dispatcher
//  Description : Self-checking bench for rl_pair_dispatcher (4x4 and 1x1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rl_pair_dispatcher;

  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pair_ready = 1'b0;
  logic [AW-1:0] home_rdaddr, neighbor_rdaddr, pair_home_id;
  logic rden, pair_valid, pair_last, busy, done;
  logic [DW-1:0] home_x = '0, home_y = '0, home_z = '0, nb_x = '0, nb_y = '0, nb_z = '0;
  logic [DW-1:0] refx, refy, refz, neighborx, neighbory, neighborz;

  // 1x1 instance signals
  logic s_start = 1'b0;
  logic s_ready = 1'b0;
  logic [1:0] s_haddr, s_naddr, s_hid;
  logic s_rden, s_valid, s_last, s_busy, s_done;
  logic [DW-1:0] s_hx = '0, s_hy = '0, s_hz = '0, s_nx = '0, s_ny = '0, s_nz = '0;
  logic [DW-1:0] s_rx, s_ry, s_rz, s_ox, s_oy, s_oz;

  always #5 clk = ~clk;

  rl_pair_dispatcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOME_NUM(4), .NEIGHBOR_NUM(4)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .home_rdaddr(home_rdaddr), .neighbor_rdaddr(neighbor_rdaddr), .rden(rden),
    .home_x(home_x), .home_y(home_y), .home_z(home_z),
    .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z),
    .refx(refx), .refy(refy), .refz(refz),
    .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
    .pair_home_id(pair_home_id), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_last(pair_last), .busy(busy), .done(done)
  );

  rl_pair_dispatcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .HOME_NUM(1), .NEIGHBOR_NUM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s_start),
    .home_rdaddr(s_haddr), .neighbor_rdaddr(s_naddr), .rden(s_rden),
    .home_x(s_hx), .home_y(s_hy), .home_z(s_hz),
    .nb_x(s_nx), .nb_y(s_ny), .nb_z(s_nz),
    .refx(s_rx), .refy(s_ry), .refz(s_rz),
    .neighborx(s_ox), .neighbory(s_oy), .neighborz(s_oz),
    .pair_home_id(s_hid), .pair_valid(s_valid), .pair_ready(s_ready),
    .pair_last(s_last), .busy(s_busy), .done(s_done)
  );

  // BRAM models: one-cycle read latency, distinct offsets per coordinate
  always @(posedge clk) begin
    if (rden) begin
      home_x <= DW'(home_rdaddr);       home_y <= DW'(home_rdaddr) + 100; home_z <= DW'(home_rdaddr) + 200;
      nb_x   <= DW'(neighbor_rdaddr);   nb_y   <= DW'(neighbor_rdaddr) + 300; nb_z <= DW'(neighbor_rdaddr) + 400;
    end
    if (s_rden) begin
      s_hx <= DW'(s_haddr); s_hy <= DW'(s_haddr) + 100; s_hz <= DW'(s_haddr) + 200;
      s_nx <= DW'(s_naddr); s_ny <= DW'(s_naddr) + 300; s_nz <= DW'(s_naddr) + 400;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_pair(input string tag, input int h, input int n, input bit last);
    check({tag, "_hid"}, pair_home_id, h);
    check({tag, "_refx"}, refx, h);
    check({tag, "_refy"}, refy, h + 100);
    check({tag, "_refz"}, refz, h + 200);
    check({tag, "_nbx"}, neighborx, n);
    check({tag, "_nby"}, neighbory, n + 300);
    check({tag, "_nbz"}, neighborz, n + 400);
    check({tag, "_last"}, pair_last, last);
  endtask

  // Full sweep with a ready policy: 0 always ready, 1 toggling 1/0,
  // 2 stalled for 20 cycles, 3 always ready with start re-pulsed in RUN.
  task automatic run_sweep(input int mode, input string tag);
    int idx = 0, reads = 0, xfers = 0, dones = 0, first_v = -1;
    bit prev_stall = 1'b0, fin = 1'b0, after_done = 1'b0;
    logic [6*DW+AW:0] prev_out = '0;
    logic [6*DW+AW:0] cur_out;
    start = 1'b1;
    pair_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      start = (mode == 3 && (cyc == 3 || cyc == 9)) ? 1'b1 : 1'b0;
      case (mode)
        1:       pair_ready = (cyc % 2 == 0);
        2:       pair_ready = (cyc >= 20);
        default: pair_ready = 1'b1;
      endcase
      #1;
      cur_out = {refx, refy, refz, neighborx, neighbory, neighborz, pair_home_id, pair_last};
      if (after_done) begin
        check({tag, "_done_pulse_len"}, done, 0);
        check({tag, "_busy_end"}, busy, 0);
        fin = 1'b1;
      end else begin
        if (rden) reads++;
        if (prev_stall) begin
          check({tag, "_stall_valid"}, pair_valid, 1);
          check({tag, "_stall_stable"}, cur_out == prev_out, 1);
        end
        if (pair_valid && first_v < 0) first_v = cyc;
        if (mode == 2 && cyc == 19) begin
          check({tag, "_stalled_reads"}, reads, 2);
          check({tag, "_stalled_valid"}, pair_valid, 1);
          check({tag, "_stalled_hid"}, pair_home_id, 0);
          check({tag, "_stalled_nbx"}, neighborx, 0);
        end
        if (pair_valid && pair_ready) begin
          check_pair(tag, idx / 4, idx % 4, idx == 15);
          idx++;
          xfers++;
        end
        check({tag, "_ahead"}, (reads - xfers) <= 2, 1);
        if (done) begin
          dones++;
          after_done = 1'b1;
        end
        prev_stall = pair_valid && !pair_ready;
        prev_out   = cur_out;
      end
    end
    start = 1'b0;
    check({tag, "_timeout"}, fin, 1);
    check({tag, "_xfers"}, xfers, 16);
    check({tag, "_reads"}, reads, 16);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_first_valid_cyc"}, first_v, 2);
  endtask

  typedef struct {
    bit ready; bit v; int h; int n; bit last; bit busy; bit done; bit rden;
  } vec_t;
  vec_t tbl [21];

  initial begin
    // Cycle-by-cycle expectations after the start edge, pair_ready held 1
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 2, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 2, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 3, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", pair_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rden, 0);
    check("rst_last", pair_last, 0);
    check("rst_haddr", home_rdaddr, 0);
    check("rst_naddr", neighbor_rdaddr, 0);
    check("rst_refx", refx, 0);
    check("rst_nbz", neighborz, 0);
    rst = 1'b1;

    // Table-driven nominal sweep, start on the first edge after reset release
    start = 1'b1;
    pair_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      start = 1'b0;
      pair_ready = tbl[k].ready;
      #1;
      check("tbl_valid", pair_valid, tbl[k].v);
      check("tbl_busy", busy, tbl[k].busy);
      check("tbl_done", done, tbl[k].done);
      check("tbl_rden", rden, tbl[k].rden);
      if (tbl[k].v) check_pair("tbl", tbl[k].h, tbl[k].n, tbl[k].last);
      else check("tbl_last_idle", pair_last, 0);
    end

    @(negedge clk);
    run_sweep(1, "toggle");
    @(negedge clk);
    run_sweep(2, "stall20");
    @(negedge clk);
    run_sweep(3, "restart");

    // Reset mid-sweep with the FIFO full after 7 transfers
    @(negedge clk);
    begin
      int xf = 0;
      start = 1'b1;
      pair_ready = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 100 && xf < 7; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        if (pair_valid && pair_ready) xf++;
      end
      check("rst7_xfers", xf, 7);
      @(negedge clk);
      pair_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst7_full_valid", pair_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("rst7_valid", pair_valid, 0);
      check("rst7_busy", busy, 0);
      check("rst7_done", done, 0);
      check("rst7_rden", rden, 0);
      check("rst7_last", pair_last, 0);
      check("rst7_hid", pair_home_id, 0);
      check("rst7_refx", refx, 0);
      check("rst7_nbx", neighborx, 0);
      check("rst7_haddr", home_rdaddr, 0);
      check("rst7_naddr", neighbor_rdaddr, 0);
      @(negedge clk);
      rst = 1'b1;
      run_sweep(0, "post_rst");
    end

    // 1x1 sweep
    @(negedge clk);
    begin
      int np = 0, nd = 0, fv = -1;
      bit fin = 1'b0;
      s_start = 1'b1;
      s_ready = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 30 && !fin; c++) begin
        @(negedge clk);
        s_start = 1'b0;
        #1;
        if (s_valid) begin
          np++;
          if (fv < 0) fv = c;
          check("one_last", s_last, 1);
          check("one_hid", s_hid, 0);
          check("one_refy", s_ry, 100);
          check("one_nbz", s_oz, 400);
        end
        if (s_done) begin
          nd++;
          fin = 1'b1;
        end
      end
      check("one_timeout", fin, 1);
      check("one_pairs", np, 1);
      check("one_dones", nd, 1);
      check("one_first_valid", fv, 2);
      @(negedge clk);
      #1;
      check("one_busy_end", s_busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
